// File: rtl/vram_blitter_pkg.sv
// Shared VRAM geometry and blitter FSM encoding, used by the blitter and the display path.
package vram_blitter_pkg;

  localparam int SCREEN_WIDTH  = 640;
  localparam int SCREEN_HEIGHT = 360;
  localparam int VRAM_A_WIDTH  = 18;
  localparam int VRAM_D_WIDTH  = 6;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/vram_blitter_if.sv
// Memory-side bus of the blitter: sprite ROM read port and VRAM write port.
interface vram_blitter_if #(
  parameter int SPR_A_WIDTH = 12
);
  import vram_blitter_pkg::*;

  logic [SPR_A_WIDTH-1:0]  spr_addr;
  logic [VRAM_D_WIDTH-1:0] spr_data;
  logic [VRAM_A_WIDTH-1:0] vram_addr;
  logic [VRAM_D_WIDTH-1:0] vram_data;
  logic                    vram_write;

  modport master (
    output spr_addr,
    input  spr_data,
    output vram_addr,
    output vram_data,
    output vram_write
  );

  modport slave (
    input  spr_addr,
    output spr_data,
    input  vram_addr,
    input  vram_data,
    input  vram_write
  );
endinterface

// File: rtl/vram_blitter_addr_gen.sv
// Stage 1 of the blit pipeline: col/row walk, sprite ROM address, VRAM address and clip flag.
module blit_addr_gen
  import vram_blitter_pkg::*;
#(
  parameter int SPR_A_WIDTH   = 12,
  parameter int SPR_DIM_WIDTH = 7
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_load,
  input  logic                     i_step,
  input  logic [9:0]               i_dst_x,
  input  logic [8:0]               i_dst_y,
  input  logic [SPR_A_WIDTH-1:0]   i_spr_base,
  input  logic [SPR_DIM_WIDTH-1:0] i_spr_w,
  input  logic [SPR_DIM_WIDTH-1:0] i_spr_h,
  output logic [SPR_A_WIDTH-1:0]   o_spr_addr,
  output logic [VRAM_A_WIDTH-1:0]  o_vram_addr,
  output logic                     o_clip,
  output logic                     o_last
);

  localparam logic [VRAM_A_WIDTH-1:0] ROW_PITCH = VRAM_A_WIDTH'(SCREEN_WIDTH);
  localparam logic [10:0]             X_LIM     = 11'(SCREEN_WIDTH);
  localparam logic [9:0]              Y_LIM     = 10'(SCREEN_HEIGHT);

  logic [9:0]               r_dst_x;
  logic [SPR_DIM_WIDTH-1:0] r_w;
  logic [SPR_DIM_WIDTH-1:0] r_h;
  logic [SPR_DIM_WIDTH-1:0] r_col;
  logic [SPR_DIM_WIDTH-1:0] r_row;
  logic [10:0]              r_x;
  logic [9:0]               r_y;
  logic [VRAM_A_WIDTH-1:0]  r_row_base;
  logic [SPR_A_WIDTH-1:0]   r_spr_addr;
  logic                     w_col_end;

  assign w_col_end = (r_col == r_w - 1'b1);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_dst_x    <= '0;
      r_w        <= '0;
      r_h        <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_row_base <= '0;
      r_spr_addr <= '0;
    end else if (i_load) begin
      r_dst_x    <= i_dst_x;
      r_w        <= i_spr_w;
      r_h        <= i_spr_h;
      r_col      <= '0;
      r_row      <= '0;
      r_x        <= {1'b0, i_dst_x};
      r_y        <= {1'b0, i_dst_y};
      r_row_base <= VRAM_A_WIDTH'(i_dst_y) * ROW_PITCH;
      r_spr_addr <= i_spr_base;
    end else if (i_step) begin
      r_spr_addr <= r_spr_addr + 1'b1;
      if (w_col_end) begin
        r_col      <= '0;
        r_row      <= r_row + 1'b1;
        r_x        <= {1'b0, r_dst_x};
        r_y        <= r_y + 1'b1;
        r_row_base <= r_row_base + ROW_PITCH;
      end else begin
        r_col <= r_col + 1'b1;
        r_x   <= r_x + 1'b1;
      end
    end
  end

  // Screen coordinates are kept one bit wider than the ports so edge sums cannot wrap.
  assign o_clip      = (r_x >= X_LIM) || (r_y >= Y_LIM);
  assign o_vram_addr = r_row_base + VRAM_A_WIDTH'(r_x);
  assign o_spr_addr  = r_spr_addr;
  assign o_last      = w_col_end && (r_row == r_h - 1'b1);

endmodule

// File: rtl/vram_blitter.sv
// Sprite-to-VRAM blitter: FSM plus stage-2 write register, one pixel per clock with edge clipping.
// Optional BLIT_TRANSPARENCY_EN suppresses writes of the TRANSPARENT_IDX colour index.
module vram_blitter
  import vram_blitter_pkg::*;
#(
  parameter int SPR_A_WIDTH   = 12,
  parameter int SPR_DIM_WIDTH = 7
`ifdef BLIT_TRANSPARENCY_EN
  , parameter logic [VRAM_D_WIDTH-1:0] TRANSPARENT_IDX = 6'h00
`endif
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic [9:0]               i_dst_x,
  input  logic [8:0]               i_dst_y,
  input  logic [SPR_A_WIDTH-1:0]   i_spr_base,
  input  logic [SPR_DIM_WIDTH-1:0] i_spr_w,
  input  logic [SPR_DIM_WIDTH-1:0] i_spr_h,
  vram_blitter_if.master           bus,
  output logic                     o_busy,
  output logic                     o_done
);

  logic [1:0]              r_state;
  logic [1:0]              w_state_nxt;
  logic                    r_wr_valid;
  logic [VRAM_A_WIDTH-1:0] r_wr_addr;
  logic                    w_load;
  logic                    w_step;
  logic                    w_nonzero;
  logic                    w_clip;
  logic                    w_last;
  logic                    w_opaque;
  logic [VRAM_A_WIDTH-1:0] w_vram_addr;
  logic [SPR_A_WIDTH-1:0]  w_spr_addr;

  assign w_nonzero = (i_spr_w != '0) && (i_spr_h != '0);
  assign w_load    = (r_state == ST_IDLE) && i_start && w_nonzero;
  assign w_step    = (r_state == ST_RUN);

  blit_addr_gen #(
    .SPR_A_WIDTH   (SPR_A_WIDTH),
    .SPR_DIM_WIDTH (SPR_DIM_WIDTH)
  ) u_addr_gen (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_load      (w_load),
    .i_step      (w_step),
    .i_dst_x     (i_dst_x),
    .i_dst_y     (i_dst_y),
    .i_spr_base  (i_spr_base),
    .i_spr_w     (i_spr_w),
    .i_spr_h     (i_spr_h),
    .o_spr_addr  (w_spr_addr),
    .o_vram_addr (w_vram_addr),
    .o_clip      (w_clip),
    .o_last      (w_last)
  );

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (i_start) w_state_nxt = w_nonzero ? ST_RUN : ST_DONE;
      ST_RUN:   if (w_last) w_state_nxt = ST_FLUSH;
      ST_FLUSH: w_state_nxt = ST_DONE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wr_valid <= w_step & ~w_clip;
      if (w_step) r_wr_addr <= w_vram_addr;
    end
  end

`ifdef BLIT_TRANSPARENCY_EN
  assign w_opaque = (bus.spr_data != TRANSPARENT_IDX);
`else
  assign w_opaque = 1'b1;
`endif

  // ROM data arrives one cycle after its address, aligned with the stage-2 register.
  assign bus.spr_addr   = w_spr_addr;
  assign bus.vram_addr  = r_wr_addr;
  assign bus.vram_data  = r_wr_valid ? bus.spr_data : '0;
  assign bus.vram_write = r_wr_valid & w_opaque;

  assign o_busy = (r_state == ST_RUN) || (r_state == ST_FLUSH);
  assign o_done = (r_state == ST_DONE);

endmodule

// File: tb/tb_vram_blitter.sv
// Directed self-checking bench for vram_blitter with a synchronous sprite ROM model.
module tb_vram_blitter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  dst_x = '0;
  logic [8:0]  dst_y = '0;
  logic [11:0] spr_base = '0;
  logic [6:0]  spr_w = '0;
  logic [6:0]  spr_h = '0;
  logic        busy;
  logic        done;

  logic [5:0]  rom [4096];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cyc = -1;
  int done_cnt = 0;
  int done_base = 0;

  logic [17:0] wr_addr_q [$];
  logic [5:0]  wr_data_q [$];
  int          wr_cyc_q  [$];

  vram_blitter_if #(.SPR_A_WIDTH(12)) bus ();

  vram_blitter dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_dst_x    (dst_x),
    .i_dst_y    (dst_y),
    .i_spr_base (spr_base),
    .i_spr_w    (spr_w),
    .i_spr_h    (spr_h),
    .bus        (bus),
    .o_busy     (busy),
    .o_done     (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    bus.spr_data <= rom[bus.spr_addr];
  end

  always @(negedge clk) begin
    if (bus.vram_write === 1'b1) begin
      wr_addr_q.push_back(bus.vram_addr);
      wr_data_q.push_back(bus.vram_data);
      wr_cyc_q.push_back(cyc);
    end
    if (done === 1'b1) begin
      done_cyc = cyc;
      done_cnt++;
    end
  end

  task automatic start_blit(input int x, input int y, input int base, input int w, input int h);
    @(posedge clk); #1;
    dst_x     = 10'(x);
    dst_y     = 9'(y);
    spr_base  = 12'(base);
    spr_w     = 7'(w);
    spr_h     = 7'(h);
    start     = 1'b1;
    start_cyc = cyc;
    done_base = done_cnt;
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clk);
      if (done_cnt != done_base) break;
    end
    if (done_cnt == done_base) begin
      n_checks++;
      n_errors++;
      $display("FAIL done_timeout: no o_done within %0d cycles", max_cyc);
    end
    #1;
  endtask

  task automatic test_reset();
    int bad = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0 || bus.vram_write !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_errors++;
      $display("FAIL reset_idle: %0d cycles with activity, required 0", bad);
    end
    n_checks++;
    if (bus.vram_addr !== 18'd0 || bus.spr_addr !== 12'd0) begin
      n_errors++;
      $display("FAIL reset_addr: vram_addr=%0d spr_addr=%0d required 0/0", bus.vram_addr, bus.spr_addr);
    end
  endtask

  task automatic test_basic();
    int exp_a [8] = '{12810, 12811, 12812, 12813, 13450, 13451, 13452, 13453};
    start_blit(10, 20, 'h100, 4, 2);
    n_checks++;
    if (busy !== 1'b1) begin
      n_errors++;
      $display("FAIL basic_busy: got %b required 1", busy);
    end
    wait_done(40);
    n_checks++;
    if (wr_addr_q.size() != 8) begin
      n_errors++;
      $display("FAIL basic_count: got %0d writes required 8", wr_addr_q.size());
    end
    for (int i = 0; i < 8 && i < wr_addr_q.size(); i++) begin
      n_checks++;
      if (wr_addr_q[i] !== 18'(exp_a[i]) || wr_data_q[i] !== 6'(i)) begin
        n_errors++;
        $display("FAIL basic_pix%0d: got addr %0d data %0d required %0d/%0d",
                 i, wr_addr_q[i], wr_data_q[i], exp_a[i], i);
      end
    end
    if (wr_cyc_q.size() == 8) begin
      n_checks++;
      if (wr_cyc_q[0] != start_cyc + 2 || wr_cyc_q[7] != start_cyc + 9) begin
        n_errors++;
        $display("FAIL basic_write_timing: first/last at +%0d/+%0d required +2/+9",
                 wr_cyc_q[0] - start_cyc, wr_cyc_q[7] - start_cyc);
      end
    end
    n_checks++;
    if (done_cyc != start_cyc + 10) begin
      n_errors++;
      $display("FAIL basic_done: at +%0d required +10", done_cyc - start_cyc);
    end
  endtask

  task automatic test_right_clip();
    start_blit(638, 0, 0, 4, 1);
    wait_done(40);
    n_checks++;
    if (wr_addr_q.size() != 2) begin
      n_errors++;
      $display("FAIL rclip_count: got %0d writes required 2", wr_addr_q.size());
    end else begin
      n_checks++;
      if (wr_addr_q[0] !== 18'd638 || wr_addr_q[1] !== 18'd639 ||
          wr_data_q[0] !== 6'd0 || wr_data_q[1] !== 6'd1) begin
        n_errors++;
        $display("FAIL rclip_pix: got %0d/%0d data %0d/%0d required 638/639 data 0/1",
                 wr_addr_q[0], wr_addr_q[1], wr_data_q[0], wr_data_q[1]);
      end
    end
    n_checks++;
    if (done_cyc != start_cyc + 6) begin
      n_errors++;
      $display("FAIL rclip_done: at +%0d required +6", done_cyc - start_cyc);
    end
  endtask

  task automatic test_bottom_clip();
    start_blit(0, 359, 'h40, 2, 3);
    wait_done(40);
    n_checks++;
    if (wr_addr_q.size() != 2) begin
      n_errors++;
      $display("FAIL bclip_count: got %0d writes required 2", wr_addr_q.size());
    end else begin
      n_checks++;
      if (wr_addr_q[0] !== 18'd229760 || wr_addr_q[1] !== 18'd229761 ||
          wr_data_q[0] !== 6'd0 || wr_data_q[1] !== 6'd1) begin
        n_errors++;
        $display("FAIL bclip_pix: got %0d/%0d data %0d/%0d required 229760/229761 data 0/1",
                 wr_addr_q[0], wr_addr_q[1], wr_data_q[0], wr_data_q[1]);
      end
    end
    n_checks++;
    if (done_cyc != start_cyc + 8) begin
      n_errors++;
      $display("FAIL bclip_done: at +%0d required +8", done_cyc - start_cyc);
    end
  endtask

  task automatic test_degenerate();
    start_blit(5, 5, 0, 0, 3);
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL zero_w_busy: got %b required 0", busy);
    end
    wait_done(10);
    n_checks++;
    if (done_cyc != start_cyc + 1 || wr_addr_q.size() != 0) begin
      n_errors++;
      $display("FAIL zero_w: done at +%0d writes %0d required +1 and 0",
               done_cyc - start_cyc, wr_addr_q.size());
    end
    start_blit(5, 5, 0, 5, 0);
    wait_done(10);
    n_checks++;
    if (done_cyc != start_cyc + 1 || wr_addr_q.size() != 0) begin
      n_errors++;
      $display("FAIL zero_h: done at +%0d writes %0d required +1 and 0",
               done_cyc - start_cyc, wr_addr_q.size());
    end
  endtask

  task automatic test_interference();
    int exp_a [6] = '{32100, 32101, 32102, 32740, 32741, 32742};
    start_blit(100, 50, 'h10, 3, 2);
    repeat (2) @(posedge clk);
    #1;
    dst_x = 10'd0; dst_y = 9'd0; spr_base = 12'h300; spr_w = 7'd1; spr_h = 7'd1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(40);
    n_checks++;
    if (done_cyc != start_cyc + 8) begin
      n_errors++;
      $display("FAIL intf_done: at +%0d required +8", done_cyc - start_cyc);
    end
    repeat (20) @(posedge clk);
    #1;
    n_checks++;
    if (wr_addr_q.size() != 6 || done_cnt != done_base + 1) begin
      n_errors++;
      $display("FAIL intf_count: writes %0d dones %0d required 6 and 1",
               wr_addr_q.size(), done_cnt - done_base);
    end
    for (int i = 0; i < 6 && i < wr_addr_q.size(); i++) begin
      n_checks++;
      if (wr_addr_q[i] !== 18'(exp_a[i]) || wr_data_q[i] !== 6'(16 + i)) begin
        n_errors++;
        $display("FAIL intf_pix%0d: got addr %0d data %0d required %0d/%0d",
                 i, wr_addr_q[i], wr_data_q[i], exp_a[i], 16 + i);
      end
    end
  endtask

  task automatic test_transparency();
    start_blit(0, 10, 'h200, 4, 1);
    wait_done(40);
    n_checks++;
    if (done_cyc != start_cyc + 6) begin
      n_errors++;
      $display("FAIL transp_done: at +%0d required +6", done_cyc - start_cyc);
    end
`ifdef BLIT_TRANSPARENCY_EN
    n_checks++;
    if (wr_addr_q.size() != 2) begin
      n_errors++;
      $display("FAIL transp_count: got %0d writes required 2", wr_addr_q.size());
    end else begin
      n_checks++;
      if (wr_addr_q[0] !== 18'd6401 || wr_data_q[0] !== 6'd5 ||
          wr_addr_q[1] !== 18'd6403 || wr_data_q[1] !== 6'd7) begin
        n_errors++;
        $display("FAIL transp_pix: got %0d:%0d %0d:%0d required 6401:5 6403:7",
                 wr_addr_q[0], wr_data_q[0], wr_addr_q[1], wr_data_q[1]);
      end
    end
`else
    n_checks++;
    if (wr_addr_q.size() != 4) begin
      n_errors++;
      $display("FAIL transp_count: got %0d writes required 4", wr_addr_q.size());
    end else begin
      n_checks++;
      if (wr_addr_q[0] !== 18'd6400 || wr_data_q[0] !== 6'd0 ||
          wr_addr_q[1] !== 18'd6401 || wr_data_q[1] !== 6'd5 ||
          wr_addr_q[2] !== 18'd6402 || wr_data_q[2] !== 6'd0 ||
          wr_addr_q[3] !== 18'd6403 || wr_data_q[3] !== 6'd7) begin
        n_errors++;
        $display("FAIL transp_pix: got %0d:%0d %0d:%0d %0d:%0d %0d:%0d required 6400:0 6401:5 6402:0 6403:7",
                 wr_addr_q[0], wr_data_q[0], wr_addr_q[1], wr_data_q[1],
                 wr_addr_q[2], wr_data_q[2], wr_addr_q[3], wr_data_q[3]);
      end
    end
`endif
  endtask

  task automatic test_reset_mid();
    start_blit(200, 100, 0, 8, 4);
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (bus.vram_write !== 1'b0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_mid_async: write=%b busy=%b required 0/0", bus.vram_write, busy);
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    n_checks++;
    if (wr_addr_q.size() != 9) begin
      n_errors++;
      $display("FAIL rst_mid_writes: got %0d writes required 9", wr_addr_q.size());
    end
    n_checks++;
    if (done_cnt != done_base) begin
      n_errors++;
      $display("FAIL rst_mid_done: got %0d pulses required 0", done_cnt - done_base);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = 6'(i);
    rom['h200] = 6'h00;
    rom['h201] = 6'h05;
    rom['h202] = 6'h00;
    rom['h203] = 6'h07;
    test_reset();
    test_basic();
    test_right_clip();
    test_bottom_clip();
    test_degenerate();
    test_interference();
    test_transparency();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
